// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop.
// Define UART_TX_BACK2BACK_EN to accept a new frame from STOP with no idle gap.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Line-mux select codes driven to the downstream output register.
  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    par_en_q;
  logic                    accept;

  // A new frame is only taken when the previous one can no longer be disturbed.
`ifdef UART_TX_BACK2BACK_EN
  assign accept = Data_Valid && ((state == S_IDLE) || (state == S_STOP));
`else
  assign accept = Data_Valid && (state == S_IDLE);
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = S_START;
    end else begin
      unique case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_START:  state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == LAST_BIT) state_nxt = par_en_q ? S_PARITY : S_STOP;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match the Moore
  // decode of the current state without a combinational path to the pins.
  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      PAR_BIT   <= 1'b0;
      SER_DATA  <= 1'b0;
      MUX_SEL   <= SEL_STOP;
      Busy      <= 1'b0;
    end else begin
      state <= state_nxt;

      unique case (state_nxt)
        S_START:  MUX_SEL <= SEL_START;
        S_DATA:   MUX_SEL <= SEL_DATA;
        S_PARITY: MUX_SEL <= SEL_PARITY;
        default:  MUX_SEL <= SEL_STOP;
      endcase
      Busy <= (state_nxt != S_IDLE);

      if (accept) begin
        shift_reg <= P_DATA;
        par_en_q  <= PAR_EN;
        PAR_BIT   <= (^P_DATA) ^ PAR_TYP;
        bit_cnt   <= '0;
      end else if (state == S_START) begin
        SER_DATA <= shift_reg[0];
      end else if (state == S_DATA) begin
        // SER_DATA tracks shift_reg[0] one step ahead of the shift itself.
        shift_reg <= shift_reg >> 1;
        SER_DATA  <= shift_reg[1];
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table-driven frames with a per-cycle
// expectation queue, plus ignore, mid-frame reset and held-request sequences.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         Data_Valid = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [1:0]   MUX_SEL;
  logic         SER_DATA;
  logic         PAR_BIT;
  logic         Busy;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .MUX_SEL    (MUX_SEL),
    .SER_DATA   (SER_DATA),
    .PAR_BIT    (PAR_BIT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] mux;
    logic       busy;
    logic       ser_chk;
    logic       ser;
    logic       par_chk;
    logic       par;
  } exp_t;

  typedef struct {
    logic [W-1:0] data;
    logic         en;
    logic         typ;
    logic         exp_par;
    int           exp_busy;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (n) sb.push_back(e);
  endtask

  task automatic push_frame(input logic [W-1:0] data, input logic en, input logic par);
    exp_t e;
    e = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, par};
    sb.push_back(e);
    for (int i = 0; i < W; i++) begin
      e = '{2'b01, 1'b1, 1'b1, data[i], 1'b1, par};
      sb.push_back(e);
    end
    if (en) begin
      e = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1, par};
      sb.push_back(e);
    end
    e = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, par};
    sb.push_back(e);
  endtask

  // One clock: advance past the edge, then compare against the next expectation.
  task automatic cycle();
    exp_t e;
    @(posedge CLK);
    #1;
    cyc++;
    if (Busy === 1'b1) busy_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("MUX_SEL", 32'(MUX_SEL), 32'(e.mux));
      check("Busy", 32'(Busy), 32'(e.busy));
      if (e.ser_chk) check("SER_DATA", 32'(SER_DATA), 32'(e.ser));
      if (e.par_chk) check("PAR_BIT", 32'(PAR_BIT), 32'(e.par));
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_MUX_SEL"}, 32'(MUX_SEL), 32'h3);
    check({tag, "_Busy"}, 32'(Busy), 32'h0);
    check({tag, "_SER_DATA"}, 32'(SER_DATA), 32'h0);
    check({tag, "_PAR_BIT"}, 32'(PAR_BIT), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1, 11};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 10};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 11};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 10};

    // Asynchronous reset takes effect without a clock edge.
    #1 RST = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;
    push_idle(2);
    drain();

    // Table-driven single frames with a one-cycle request.
    foreach (vecs[k]) begin
      P_DATA     = vecs[k].data;
      PAR_EN     = vecs[k].en;
      PAR_TYP    = vecs[k].typ;
      Data_Valid = 1'b1;
      push_frame(vecs[k].data, vecs[k].en, vecs[k].exp_par);
      push_idle(1);
      busy_cnt = 0;
      cycle();
      Data_Valid = 1'b0;
      P_DATA     = ~vecs[k].data;
      PAR_EN     = ~vecs[k].en;
      PAR_TYP    = ~vecs[k].typ;
      drain();
      check("busy_len", 32'(busy_cnt), 32'(vecs[k].exp_busy));
    end

    // A request during DATA must not disturb the frame or start another one.
    P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h00, 1'b1, 1'b0);
    push_idle(2);
    cycle();
    Data_Valid = 1'b0;
    cycle();
    cycle();
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    cycle();
    Data_Valid = 1'b0;
    drain();

    // Reset during the 4th DATA cycle aborts the frame; the next one is clean.
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    push_frame(8'hA5, 1'b1, 1'b1);
    cycle();
    Data_Valid = 1'b0;
    repeat (4) cycle();
    #2 RST = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    sb.delete();
    @(negedge CLK);
    RST = 1'b1;
    push_idle(1);
    drain();
    P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    push_frame(8'hC3, 1'b1, 1'b1);
    push_idle(1);
    busy_cnt = 0;
    cycle();
    Data_Valid = 1'b0;
    drain();
    check("post_reset_busy_len", 32'(busy_cnt), 32'd11);

    // Request held high across two frames; parity type changes between them.
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    push_frame(8'h55, 1'b1, 1'b0);
`ifndef UART_TX_BACK2BACK_EN
    push_idle(1);
`endif
    push_frame(8'hAA, 1'b1, 1'b1);
    push_idle(2);
    cycle();
    P_DATA  = 8'hAA;
    PAR_TYP = 1'b1;
    while (sb.size() > (W + 3 + 2 - 1)) cycle();
    Data_Valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
